// File: rtl/dpu_pio_pkg.sv
// Shared PIO definitions: command encodings, memory selects, FSM states and
// region-base helpers (also imported by the DMA bridge).
package dpu_pio_pkg;

  localparam logic [2:0] CMD_WR_BYTE  = 3'd0;
  localparam logic [2:0] CMD_RD_BYTE  = 3'd2;
  localparam logic [2:0] CMD_WR_SCALE = 3'd5;
  localparam logic [2:0] CMD_WR_DESC  = 3'd6;

  localparam logic [1:0] SEL_WEIGHT = 2'd0;
  localparam logic [1:0] SEL_BIAS   = 2'd1;
  localparam logic [1:0] SEL_FMAP   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RSP     = 3'd3,
    S_GAP     = 3'd4
  } pio_state_t;

  function automatic int unsigned bias_base(input int unsigned max_wbuf);
    return max_wbuf;
  endfunction

  function automatic int unsigned fmap_base(input int unsigned max_wbuf,
                                            input int unsigned max_ch);
    return max_wbuf + max_ch * 4;
  endfunction

endpackage

// File: rtl/dpu_pio_addr_decode.sv
// Flat PIO address -> region select, region-local offset and in-range flag.
module dpu_pio_addr_decode
  import dpu_pio_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 24,
  parameter int unsigned MAX_WBUF   = 147456,
  parameter int unsigned MAX_CH     = 256,
  parameter int unsigned FMAP_BYTES = 65536
) (
  input  logic [ADDR_BITS-1:0] i_cmd_addr,
  output logic [1:0]           o_mem_sel,
  output logic [ADDR_BITS-1:0] o_local_off,
  output logic                 o_in_range
);

  // One extra bit so base+size never wraps for large parameter choices.
  localparam logic [ADDR_BITS:0] BIAS_B = (ADDR_BITS+1)'(bias_base(MAX_WBUF));
  localparam logic [ADDR_BITS:0] FMAP_B = (ADDR_BITS+1)'(fmap_base(MAX_WBUF, MAX_CH));
  localparam logic [ADDR_BITS:0] END_B  = FMAP_B + (ADDR_BITS+1)'(FMAP_BYTES);

  logic [ADDR_BITS:0] w_addr;
  assign w_addr = {1'b0, i_cmd_addr};

  always_comb begin
    o_mem_sel   = SEL_WEIGHT;
    o_local_off = '0;
    o_in_range  = 1'b0;
    if (w_addr < BIAS_B) begin
      o_local_off = i_cmd_addr;
      o_in_range  = 1'b1;
    end else if (w_addr < FMAP_B) begin
      o_mem_sel   = SEL_BIAS;
      o_local_off = ADDR_BITS'(w_addr - BIAS_B);
      o_in_range  = 1'b1;
    end else if (w_addr < END_B) begin
      o_mem_sel   = SEL_FMAP;
      o_local_off = ADDR_BITS'(w_addr - FMAP_B);
      o_in_range  = 1'b1;
    end
  end

endmodule

// File: rtl/dpu_pio_responder.sv
// PIO command responder: byte reads/writes into weight/bias/fmap memories plus
// scale and layer-descriptor register writes, with sticky error flags.
//   state     | meaning
//   S_IDLE    | cmd_ready high, waiting for a command
//   S_EXEC    | strobe for the accepted command is on the outputs
//   S_RD_WAIT | memory read data arrives, captured into rsp_data
//   S_RSP     | rsp_valid pulse
//   S_GAP     | dead cycle so a stale cmd_valid is not re-accepted
module dpu_pio_responder
  import dpu_pio_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 24,
  parameter int unsigned MAX_WBUF   = 147456,
  parameter int unsigned MAX_CH     = 256,
  parameter int unsigned FMAP_BYTES = 65536,
  parameter int unsigned DESC_BYTES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_type,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [7:0]           cmd_data,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [1:0]           mem_sel,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 scale_we,
  output logic                 desc_we,
  output logic [9:0]           reg_addr,
  output logic [7:0]           reg_wdata,
  output logic                 err_addr,
  output logic                 err_cmd,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam logic [ADDR_BITS:0] SCALE_LIM = (ADDR_BITS+1)'(MAX_CH * 4);
  localparam logic [ADDR_BITS:0] DESC_LIM  = (ADDR_BITS+1)'(DESC_BYTES);

  pio_state_t          r_state;
  logic [2:0]          r_type;
  logic                r_rd_hit;

  logic [1:0]          w_sel;
  logic [ADDR_BITS-1:0] w_off;
  logic                w_in_range;
  logic [ADDR_BITS:0]  w_addr_ext;
  logic                w_accept;
  logic                w_type_ok;
  logic                w_addr_ok;
  logic                w_err_addr_set;
  logic                w_err_cmd_set;

  dpu_pio_addr_decode #(
    .ADDR_BITS (ADDR_BITS),
    .MAX_WBUF  (MAX_WBUF),
    .MAX_CH    (MAX_CH),
    .FMAP_BYTES(FMAP_BYTES)
  ) u_decode (
    .i_cmd_addr (cmd_addr),
    .o_mem_sel  (w_sel),
    .o_local_off(w_off),
    .o_in_range (w_in_range)
  );

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_addr_ext = {1'b0, cmd_addr};

  always_comb begin
    w_type_ok = 1'b1;
    w_addr_ok = 1'b0;
    case (cmd_type)
      CMD_WR_BYTE, CMD_RD_BYTE: w_addr_ok = w_in_range;
      CMD_WR_SCALE:             w_addr_ok = (w_addr_ext < SCALE_LIM);
      CMD_WR_DESC:              w_addr_ok = (w_addr_ext < DESC_LIM);
      default:                  w_type_ok = 1'b0;
    endcase
  end

  assign w_err_addr_set = w_accept && w_type_ok && !w_addr_ok;
  assign w_err_cmd_set  = w_accept && !w_type_ok;

  // Strobes are registered at the accept edge so they are visible in S_EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_type    <= '0;
      r_rd_hit  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      mem_sel   <= SEL_WEIGHT;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      scale_we  <= 1'b0;
      desc_we   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      err_addr  <= 1'b0;
      err_cmd   <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      scale_we  <= 1'b0;
      desc_we   <= 1'b0;
      rsp_valid <= 1'b0;
      err_addr  <= w_err_addr_set || (err_addr && !err_clr);
      err_cmd   <= w_err_cmd_set  || (err_cmd  && !err_clr);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_type   <= cmd_type;
            r_rd_hit <= (cmd_type == CMD_RD_BYTE) && w_addr_ok;
            r_state  <= S_EXEC;
            if (w_addr_ok) begin
              case (cmd_type)
                CMD_WR_BYTE: begin
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_sel   <= w_sel;
                  mem_addr  <= w_off;
                  mem_wdata <= cmd_data;
                end
                CMD_RD_BYTE: begin
                  mem_en   <= 1'b1;
                  mem_sel  <= w_sel;
                  mem_addr <= w_off;
                end
                CMD_WR_SCALE: begin
                  scale_we  <= 1'b1;
                  reg_addr  <= cmd_addr[9:0];
                  reg_wdata <= cmd_data;
                end
                CMD_WR_DESC: begin
                  desc_we   <= 1'b1;
                  reg_addr  <= cmd_addr[9:0];
                  reg_wdata <= cmd_data;
                end
                default: ;
              endcase
            end
          end
        end
        S_EXEC:    r_state <= (r_type == CMD_RD_BYTE) ? S_RD_WAIT : S_IDLE;
        S_RD_WAIT: begin
          rsp_data  <= r_rd_hit ? mem_rdata : 8'h00;
          rsp_valid <= 1'b1;
          r_state   <= S_RSP;
        end
        S_RSP:     r_state <= S_GAP;
        S_GAP:     r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule
